// File: rtl/pio_fabric_pkg.sv
// Shared types and helpers for the host-to-PIO fabric and its address decoder.
package pio_fabric_pkg;

  // Transaction FSM: one request outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Response error flag values and the error counter ceiling.
  localparam logic        ERR_OK      = 1'b0;
  localparam logic        ERR_SET     = 1'b1;
  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Width of a slave index; a single slave still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pio_fabric_if.sv
// Host request/response and PIO fan-out bus of the fabric.
// The slave modport is the fabric's view; master is the view of whatever
// sits around it (host plus the PIO channels).
interface pio_fabric_if #(
  parameter int          AW         = 32,
  parameter int          DW         = 32,
  parameter int          NUM_SLAVES = 4,
  parameter int unsigned SLAVE_SIZE = 32'h0100_0000
);
  localparam int SAW = $clog2(SLAVE_SIZE);

  logic                     h_req_valid;
  logic                     h_req_ready;
  logic                     h_req_write;
  logic [AW-1:0]            h_req_addr;
  logic [DW-1:0]            h_req_wdata;
  logic                     h_rsp_valid;
  logic                     h_rsp_ready;
  logic [DW-1:0]            h_rsp_rdata;
  logic                     h_rsp_err;
  logic [NUM_SLAVES-1:0]    s_req_valid;
  logic                     s_req_write;
  logic [SAW-1:0]           s_req_addr;
  logic [DW-1:0]            s_req_wdata;
  logic [NUM_SLAVES-1:0]    s_ack;
  logic [NUM_SLAVES*DW-1:0] s_rdata;

  modport slave (
    input  h_req_valid, h_req_write, h_req_addr, h_req_wdata, h_rsp_ready,
           s_ack, s_rdata,
    output h_req_ready, h_rsp_valid, h_rsp_rdata, h_rsp_err,
           s_req_valid, s_req_write, s_req_addr, s_req_wdata
  );

  modport master (
    output h_req_valid, h_req_write, h_req_addr, h_req_wdata, h_rsp_ready,
           s_ack, s_rdata,
    input  h_req_ready, h_rsp_valid, h_rsp_rdata, h_rsp_err,
           s_req_valid, s_req_write, s_req_addr, s_req_wdata
  );

endinterface

// File: rtl/pio_addr_decode.sv
// Combinational window decoder: maps a byte address onto one of NUM_SLAVES
// equal power-of-two windows starting at HOST_BASE.
module pio_addr_decode
  import pio_fabric_pkg::*;
#(
  parameter int            AW         = 32,
  parameter logic [AW-1:0] HOST_BASE  = '0,
  parameter int            SAW        = 24,
  parameter int            NUM_SLAVES = 4,
  parameter int            IW         = idx_w(NUM_SLAVES)
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_hit,
  output logic [IW-1:0] o_idx
);

  // Window number is (addr - base) >> SAW. Only the bits above SAW are
  // subtracted, with the borrow from the low part folded in; the extra top
  // bit is the sign of the full subtraction, so addresses below the base
  // and near the top of the space never wrap into a valid window.
  localparam int WW = AW - SAW + 1;

  logic          w_borrow;
  logic [WW-1:0] w_win;

  assign w_borrow = (i_addr[SAW-1:0] < HOST_BASE[SAW-1:0]);
  assign w_win    = {1'b0, i_addr[AW-1:SAW]} - {1'b0, HOST_BASE[AW-1:SAW]}
                  - {{(WW-1){1'b0}}, w_borrow};
  assign o_hit    = ~w_win[WW-1] && ({1'b0, w_win[WW-2:0]} < WW'(NUM_SLAVES));
  assign o_idx    = w_win[IW-1:0];

endmodule

// File: rtl/pio_fabric.sv
// Host-to-PIO bridge: decodes each host request to a slave window, runs a
// req/ack handshake with a timeout, and returns data plus an error flag.
module pio_fabric
  import pio_fabric_pkg::*;
#(
  parameter int            AW         = 32,
  parameter int            DW         = 32,
  parameter logic [AW-1:0] HOST_BASE  = '0,
  parameter int unsigned   SLAVE_SIZE = 32'h0100_0000,
  parameter int            NUM_SLAVES = 4,
  parameter int            TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  pio_fabric_if.slave bus,
  output logic [15:0] err_count
);

  localparam int          SAW = $clog2(SLAVE_SIZE);
  localparam int          IW  = idx_w(NUM_SLAVES);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  logic                  w_hit;
  logic [IW-1:0]         w_idx;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                  w_ack;
  logic [DW-1:0]         w_sel_rdata;
  logic [15:0]           w_cnt_nxt;

  state_t                r_state;
  logic                  r_req_ready;
  logic [NUM_SLAVES-1:0] r_req_valid;
  logic                  r_req_write;
  logic [SAW-1:0]        r_req_addr;
  logic [DW-1:0]         r_req_wdata;
  logic                  r_rsp_valid;
  logic [DW-1:0]         r_rsp_rdata;
  logic                  r_rsp_err;
  logic [15:0]           r_cnt;
  logic [15:0]           r_err_count;

  pio_addr_decode #(
    .AW         (AW),
    .HOST_BASE  (HOST_BASE),
    .SAW        (SAW),
    .NUM_SLAVES (NUM_SLAVES),
    .IW         (IW)
  ) u_decode (
    .i_addr (bus.h_req_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // One-hot slave select for a new request, and read data of the slave
  // currently being driven (the held one-hot valid doubles as the mux select).
  always_comb begin
    w_onehot    = '0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_idx == IW'(i))  w_onehot[i] = 1'b1;
      if (r_req_valid[i])   w_sel_rdata = bus.s_rdata[i*DW +: DW];
    end
  end

  // Only the selected slave's ack counts; others are masked off here.
  assign w_ack     = |(bus.s_ack & r_req_valid);
  assign w_cnt_nxt = r_cnt + 16'd1;

  // Transaction FSM with timeout counter, response registers and error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_req_valid <= '0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
      r_cnt       <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && bus.h_req_valid) begin
            r_req_ready <= 1'b0;
            r_cnt       <= '0;
            if (w_hit) begin
              r_state     <= ST_ISSUE;
              r_req_valid <= w_onehot;
              r_req_write <= bus.h_req_write;
              r_req_addr  <= bus.h_req_addr[SAW-1:0];
              r_req_wdata <= bus.h_req_wdata;
            end else begin
              // Unmapped: answer straight away, no slave sees the request.
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= ERR_SET;
              r_rsp_rdata <= '0;
            end
          end
        end
        ST_ISSUE: begin
          // Ack wins over a timeout landing in the same cycle.
          if (w_ack) begin
            r_state     <= ST_RESP;
            r_req_valid <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_OK;
            r_rsp_rdata <= r_req_write ? '0 : w_sel_rdata;
            r_cnt       <= '0;
          end else if (w_cnt_nxt >= TMO) begin
            r_state     <= ST_RESP;
            r_req_valid <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_SET;
            r_rsp_rdata <= '0;
            r_cnt       <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        ST_RESP: begin
          if (bus.h_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= ERR_OK;
            r_rsp_rdata <= '0;
            if (r_rsp_err && (r_err_count != ERR_CNT_MAX))
              r_err_count <= r_err_count + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.h_req_ready = r_req_ready;
  assign bus.h_rsp_valid = r_rsp_valid;
  assign bus.h_rsp_rdata = r_rsp_rdata;
  assign bus.h_rsp_err   = r_rsp_err;
  assign bus.s_req_valid = r_req_valid;
  assign bus.s_req_write = r_req_write;
  assign bus.s_req_addr  = r_req_addr;
  assign bus.s_req_wdata = r_req_wdata;
  assign err_count       = r_err_count;

endmodule
